// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: word/length widths, sequencer state encoding and chunk sizing.
`default_nettype none

package jtag_pkg;

    localparam int C_WORD_BITS = 32;
    localparam int C_LEN_BITS  = 16;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_FETCH = 5'b00010,
        S_START = 5'b00100,
        S_WAIT  = 5'b01000,
        S_DRAIN = 5'b10000
    } seq_state_t;

    // Bits carried by the next chunk: a full word, or whatever is left.
    function automatic logic [C_LEN_BITS-1:0] chunk_len(input logic [C_LEN_BITS-1:0] rem);
        return (rem >= C_LEN_BITS'(C_WORD_BITS)) ? C_LEN_BITS'(C_WORD_BITS) : rem;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_shift_sequencer.sv
// Splits a JTAG shift command into 32-bit chunks, feeds the engine one chunk at a
// time and returns each captured TDO word, with a per-chunk completion timeout.
`default_nettype none

module jtag_shift_sequencer
    import jtag_pkg::*;
#(
    parameter int C_DONE_TIMEOUT = 4096
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   CMD_VALID,
    output logic                   CMD_READY,
    input  logic [C_LEN_BITS-1:0]  CMD_LENGTH,
    input  logic                   WR_VALID,
    output logic                   WR_READY,
    input  logic [C_WORD_BITS-1:0] WR_TMS,
    input  logic [C_WORD_BITS-1:0] WR_TDI,
    output logic                   RD_VALID,
    input  logic                   RD_READY,
    output logic [C_WORD_BITS-1:0] RD_TDO,
    output logic                   BUSY,
    output logic                   ERROR,
    output logic                   ENG_ENABLE,
    output logic [C_WORD_BITS-1:0] ENG_LENGTH,
    output logic [C_WORD_BITS-1:0] ENG_TMS,
    output logic [C_WORD_BITS-1:0] ENG_TDI,
    input  logic                   ENG_DONE,
    input  logic [C_WORD_BITS-1:0] ENG_TDO
);

    localparam int TMR_BITS = $clog2(C_DONE_TIMEOUT) + 1;
    localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(C_DONE_TIMEOUT - 1);

    seq_state_t            state;
    seq_state_t            state_next;
    logic [C_LEN_BITS-1:0] remaining;
    logic [C_LEN_BITS-1:0] chunk;
    logic [TMR_BITS-1:0]   wait_cnt;
    logic                  cmd_fire;
    logic                  wr_fire;
    logic                  done_hit;
    logic                  timed_out;

    assign chunk      = chunk_len(remaining);
    assign CMD_READY  = (state == S_IDLE);
    // A zero-length command passes through FETCH without ever offering WR_READY.
    assign WR_READY   = (state == S_FETCH) && (remaining != '0);
    assign ENG_ENABLE = (state == S_START);
    assign RD_VALID   = (state == S_DRAIN);
    assign BUSY       = (state != S_IDLE);

    assign cmd_fire  = CMD_VALID && CMD_READY;
    assign wr_fire   = WR_VALID && WR_READY;
    assign done_hit  = (state == S_WAIT) && ENG_DONE;
    assign timed_out = (state == S_WAIT) && !ENG_DONE && (wait_cnt == TMR_LAST);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (cmd_fire) state_next = S_FETCH;
            S_FETCH: begin
                if (remaining == '0)
                    state_next = S_IDLE;
                else if (wr_fire)
                    state_next = S_START;
            end
            S_START: state_next = S_WAIT;
            S_WAIT: begin
                if (ENG_DONE)
                    state_next = S_DRAIN;
                else if (timed_out)
                    state_next = S_IDLE;
            end
            S_DRAIN: begin
                if (RD_READY)
                    state_next = (remaining != '0) ? S_FETCH : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state      <= S_IDLE;
            remaining  <= '0;
            wait_cnt   <= '0;
            ERROR      <= 1'b0;
            ENG_LENGTH <= '0;
            ENG_TMS    <= '0;
            ENG_TDI    <= '0;
            RD_TDO     <= '0;
        end else begin
            state <= state_next;

            if (cmd_fire) begin
                remaining <= CMD_LENGTH;
                ERROR     <= 1'b0;
            end

            if (wr_fire) begin
                ENG_TMS    <= WR_TMS;
                ENG_TDI    <= WR_TDI;
                ENG_LENGTH <= {{(C_WORD_BITS - C_LEN_BITS){1'b0}}, chunk};
                remaining  <= remaining - chunk;
            end

            if (state == S_START)
                wait_cnt <= '0;
            else if (state == S_WAIT)
                wait_cnt <= wait_cnt + 1'b1;

            if (done_hit)
                RD_TDO <= ENG_TDO;

            // Abandon the whole command: nothing further is fetched or returned.
            if (timed_out) begin
                ERROR     <= 1'b1;
                remaining <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jtag_shift_sequencer.sv
// Directed bench for jtag_shift_sequencer; the bench plays the engine and both word streams.
`default_nettype none

module tb_jtag_shift_sequencer;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [15:0] CMD_LENGTH = '0;
    logic        WR_VALID = 1'b0;
    logic        WR_READY;
    logic [31:0] WR_TMS = '0;
    logic [31:0] WR_TDI = '0;
    logic        RD_VALID;
    logic        RD_READY = 1'b0;
    logic [31:0] RD_TDO;
    logic        BUSY;
    logic        ERROR;
    logic        ENG_ENABLE;
    logic [31:0] ENG_LENGTH;
    logic [31:0] ENG_TMS;
    logic [31:0] ENG_TDI;
    logic        ENG_DONE = 1'b0;
    logic [31:0] ENG_TDO = '0;

    int checks = 0;
    int errors = 0;

    jtag_shift_sequencer #(.C_DONE_TIMEOUT(16)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_LENGTH(CMD_LENGTH),
        .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_TMS(WR_TMS), .WR_TDI(WR_TDI),
        .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_TDO(RD_TDO),
        .BUSY(BUSY), .ERROR(ERROR),
        .ENG_ENABLE(ENG_ENABLE), .ENG_LENGTH(ENG_LENGTH), .ENG_TMS(ENG_TMS), .ENG_TDI(ENG_TDI),
        .ENG_DONE(ENG_DONE), .ENG_TDO(ENG_TDO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_error"}, ERROR, 0);
        check({tag, "_rd_valid"}, RD_VALID, 0);
        check({tag, "_eng_en"}, ENG_ENABLE, 0);
        check({tag, "_eng_len"}, ENG_LENGTH, 0);
        check({tag, "_eng_tms"}, ENG_TMS, 0);
        check({tag, "_eng_tdi"}, ENG_TDI, 0);
        check({tag, "_rd_tdo"}, RD_TDO, 0);
        check({tag, "_cmd_ready"}, CMD_READY, 1);
        check({tag, "_wr_ready"}, WR_READY, 0);
    endtask

    task automatic issue_cmd(input logic [15:0] len);
        CMD_VALID = 1'b1;
        CMD_LENGTH = len;
        tick();
        CMD_VALID = 1'b0;
        check("cmd_busy", BUSY, 1);
        check("cmd_ready_low", CMD_READY, 0);
    endtask

    // Starts in FETCH; returns in FETCH (more chunks) or IDLE (last chunk).
    task automatic do_chunk(input logic [31:0] tms, input logic [31:0] tdi, input logic [31:0] tdo,
                            input logic [31:0] exp_len, input int wait_cycles, input int hold,
                            input bit last);
        check("wr_ready", WR_READY, 1);
        check("eng_en_fetch", ENG_ENABLE, 0);
        WR_VALID = 1'b1;
        WR_TMS = tms;
        WR_TDI = tdi;
        tick();
        WR_VALID = 1'b0;
        check("eng_en_start", ENG_ENABLE, 1);
        check("eng_len", ENG_LENGTH, exp_len);
        check("eng_tms", ENG_TMS, tms);
        check("eng_tdi", ENG_TDI, tdi);
        check("wr_ready_start", WR_READY, 0);
        tick();
        check("eng_en_pulse", ENG_ENABLE, 0);
        check("cmd_held_off", CMD_READY, 0);
        repeat (wait_cycles) tick();
        check("rd_valid_wait", RD_VALID, 0);
        ENG_DONE = 1'b1;
        ENG_TDO = tdo;
        tick();
        ENG_DONE = 1'b0;
        ENG_TDO = 32'hFFFF_FFFF;
        check("rd_valid", RD_VALID, 1);
        check("rd_tdo", RD_TDO, tdo);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_rd_valid", RD_VALID, 1);
            check("hold_rd_tdo", RD_TDO, tdo);
            check("hold_wr_ready", WR_READY, 0);
            check("hold_eng_en", ENG_ENABLE, 0);
        end
        RD_READY = 1'b1;
        tick();
        RD_READY = 1'b0;
        check("rd_valid_after", RD_VALID, 0);
        check("busy_after", BUSY, last ? 0 : 1);
        check("eng_len_hold", ENG_LENGTH, exp_len);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_reset_outputs("reset");
        RESET_N = 1'b1;
        tick();
        check_reset_outputs("post_reset");

        // Single 5-bit chunk
        issue_cmd(16'd5);
        do_chunk(32'h0000_001F, 32'h0000_000A, 32'h0000_0013, 32'd5, 2, 0, 1'b1);
        check("c5_idle", CMD_READY, 1);

        // ENG_DONE outside WAIT leaves the captured word alone
        ENG_DONE = 1'b1;
        ENG_TDO = 32'hDEAD_BEEF;
        tick();
        ENG_DONE = 1'b0;
        check("stray_done_rd_valid", RD_VALID, 0);
        check("stray_done_rd_tdo", RD_TDO, 32'h0000_0013);
        check("stray_done_busy", BUSY, 0);

        // 70 bits -> 32, 32, 6 with a 10-cycle drain stall on the first word
        issue_cmd(16'd70);
        do_chunk(32'hA5A5_A5A5, 32'h1234_5678, 32'hCAFE_0001, 32'd32, 0, 10, 1'b0);
        do_chunk(32'h0F0F_0F0F, 32'h8765_4321, 32'hCAFE_0002, 32'd32, 3, 0, 1'b0);
        do_chunk(32'h0000_003F, 32'h0000_0015, 32'h0000_002A, 32'd6, 1, 0, 1'b1);

        // Zero-length command
        issue_cmd(16'd0);
        check("zero_wr_ready", WR_READY, 0);
        check("zero_eng_en", ENG_ENABLE, 0);
        tick();
        check("zero_busy", BUSY, 0);
        check("zero_rd_valid", RD_VALID, 0);
        check("zero_eng_en2", ENG_ENABLE, 0);

        // Timeout: 16 WAIT cycles with no ENG_DONE
        issue_cmd(16'd5);
        WR_VALID = 1'b1;
        WR_TMS = 32'h1;
        WR_TDI = 32'h2;
        tick();
        WR_VALID = 1'b0;
        check("to_start", ENG_ENABLE, 1);
        tick();
        repeat (15) tick();
        check("to_wait16_error", ERROR, 0);
        check("to_wait16_busy", BUSY, 1);
        tick();
        check("to_error", ERROR, 1);
        check("to_idle", BUSY, 0);
        check("to_no_rd", RD_VALID, 0);
        tick();
        check("to_error_sticky", ERROR, 1);
        check("to_stays_idle", WR_READY, 0);
        issue_cmd(16'd5);
        check("to_error_cleared", ERROR, 0);
        do_chunk(32'h0000_0011, 32'h0000_0007, 32'h0000_001C, 32'd5, 0, 0, 1'b1);

        // Reset during WAIT of chunk 2 of a 70-bit command
        issue_cmd(16'd70);
        do_chunk(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'd32, 0, 0, 1'b0);
        WR_VALID = 1'b1;
        WR_TMS = 32'h4444_4444;
        WR_TDI = 32'h5555_5555;
        tick();
        WR_VALID = 1'b0;
        tick();
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        check_reset_outputs("mid_reset");
        tick();
        check("mid_reset_stays_idle", BUSY, 0);
        issue_cmd(16'd5);
        do_chunk(32'h0000_0015, 32'h0000_000E, 32'h0000_0009, 32'd5, 1, 0, 1'b1);
        check("after_reset_idle", CMD_READY, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/jtag_shift_sequencer.md
JTAG_SHIFT_SEQUENCER -- requirements
Module: jtag_shift_sequencer

Interface
REQ-001 SHALL have parameter C_DONE_TIMEOUT, default 4096, meaning the maximum CLK cycles to wait for ENG_DONE per chunk.
REQ-002 SHALL have ports: CLK  in  1  clock (all logic rising-edge).
REQ-003 RESET_N  in  1  reset, synchronous, active-low.
REQ-004 CMD_VALID / CMD_READY  in / out  1 / 1  command handshake.
REQ-005 CMD_LENGTH  in  16  total bits to shift.
REQ-006 WR_VALID / WR_READY  in / out  1 / 1  outbound word handshake.
REQ-007 WR_TMS, WR_TDI  in  32 each  LSB-first TMS/TDI bits for the next chunk.
REQ-008 RD_VALID / RD_READY  out / in  1 / 1  captured word handshake.
REQ-009 RD_TDO  out  32  captured TDO word.
REQ-010 BUSY  out  1  command in progress; ERROR  out  1  sticky timeout flag.
REQ-011 ENG_ENABLE  out  1; ENG_LENGTH  out  32; ENG_TMS, ENG_TDI  out  32 each: the engine request.
REQ-012 ENG_DONE  in  1; ENG_TDO  in  32: the engine completion and capture.

Function
REQ-013 SHALL split each command into chunks of min(remaining, 32) bits; remaining is a 16-bit register loaded from CMD_LENGTH and decremented by each chunk length.
REQ-014 FSM states and transitions SHALL be:
- IDLE -> FETCH on a CMD handshake.
- FETCH -> START on a WR handshake.
- START -> WAIT (START lasts exactly 1 cycle).
- WAIT -> DRAIN on ENG_DONE.
- DRAIN -> FETCH or IDLE on an RD handshake.
REQ-015 CMD_READY SHALL be 1 only in IDLE; WR_READY SHALL be 1 only in FETCH.
REQ-016 FETCH SHALL register WR_TMS, WR_TDI and the chunk length onto ENG_TMS, ENG_TDI and ENG_LENGTH, which SHALL hold until the next FETCH handshake.
REQ-017 ENG_ENABLE SHALL be high only in START, a single-cycle pulse; it is therefore low for at least 1 cycle between chunks, which guarantees a rising edge per chunk.
REQ-018 In WAIT, ENG_DONE high SHALL register ENG_TDO into RD_TDO in that same edge; RD_VALID SHALL assert the next cycle (DRAIN).
REQ-019 In DRAIN, RD_VALID SHALL remain high and RD_TDO stable until RD_READY; after the handshake the FSM SHALL go to FETCH if remaining is nonzero, else to IDLE.
REQ-020 Latency: ENG_ENABLE SHALL assert 1 cycle after the WR handshake; RD_VALID SHALL assert 1 cycle after ENG_DONE.
REQ-021 CMD_LENGTH==0 SHALL be accepted and SHALL return to IDLE next cycle with no WR, ENG or RD activity.
REQ-022 ENG_DONE outside WAIT SHALL be ignored.
REQ-023 WAIT SHALL count cycles; reaching C_DONE_TIMEOUT SHALL set ERROR, abandon the command (remaining cleared) and go to IDLE with no RD word.
REQ-024 ERROR SHALL clear on the next CMD handshake.
REQ-025 BUSY SHALL be 1 in every state except IDLE.
REQ-026 CMD_VALID while BUSY SHALL be held off (CMD_READY=0), not dropped.

Reset
REQ-027 RESET_N low at a CLK edge SHALL force:
- IDLE
- BUSY=0, ERROR=0, RD_VALID=0, ENG_ENABLE=0
- ENG_LENGTH=0, ENG_TMS=0, ENG_TDI=0, RD_TDO=0
- remaining=0, timeout counter=0
REQ-028 Reset mid-command SHALL discard all pending chunks; any engine activity already in flight is the engine's own reset responsibility.

Structure
REQ-029 Shared package jtag_pkg SHALL hold C_WORD_BITS=32, the 16-bit length width and the FSM state encoding (one-hot, 5 states).
REQ-030 No sub-module; jtag_engine SHALL be instantiated beside this block at the parent level and wired ENG_* to its ports.

Verification
REQ-031 CMD_LENGTH=5, WR_TMS=0x1F, WR_TDI=0x0A -> one START with ENG_LENGTH=5 and ENG_TMS=0x1F; after ENG_DONE, one RD word; then IDLE.
REQ-032 CMD_LENGTH=70 -> three chunks with ENG_LENGTH 32, 32, 6; three RD words in order; ENG_ENABLE low ≥1 cycle between pulses.
REQ-033 CMD_LENGTH=0 -> CMD handshake, BUSY high 1 cycle, no ENG_ENABLE, no RD_VALID.
REQ-034 RD_READY held low 10 cycles in DRAIN -> RD_TDO stable, no further WR_READY or ENG_ENABLE until the handshake.
REQ-035 C_DONE_TIMEOUT=16 with ENG_DONE never asserted -> ERROR=1 at the 16th WAIT cycle, IDLE, no RD word; next command clears ERROR.
REQ-036 RESET_N low during WAIT of chunk 2 of a 70-bit command -> all outputs at reset values; a new 5-bit command then completes normally.
